// File: rtl/fp32_mac_core.sv
// Multi-cycle single-issue fused-style multiply-add: R = round(round(A*B) + C), binary32, RNE.
// Sits between the UART receive frame and the transmit handshake; one operation in flight at a time.
module fp32_mac_core #(
   parameter logic [31:0] CANON_NAN = 32'h7FC00000
) (
   input  logic        CLK_I,
   input  logic        RSTL_I,
   input  logic        IN_VALID_I,
   input  logic [95:0] IN_DATA_I,
   output logic        IN_READY_O,
   output logic        OUT_VALID_O,
   input  logic        OUT_READY_I,
   output logic [31:0] OUT_DATA_O,
   output logic        OVERRUN_O
);

   typedef enum logic [2:0] {
      IDLE, MUL, PRND, ALIGN, ADD, NORM, RND, HOLD
   } state_t;

   state_t state, state_next;

   logic valid_prev;
   logic rise;

   logic [31:0] a_q, b_q, c_q;
   logic        spec_q;
   logic [31:0] spec_val_q;
   logic        prod_sign_q;
   logic signed [10:0] pexp_q;
   logic [47:0] pman_q;
   logic signed [10:0] re_q;
   logic [23:0] rm_q;
   logic [26:0] al_lg_q, al_sm_q;
   logic signed [10:0] al_exp_q;
   logic        al_sign_q, al_sub_q;
   logic [27:0] sum_q;
   logic        sum_zero_q;
   logic [26:0] norm_q;
   logic signed [10:0] norm_exp_q;
   logic [31:0] res_q;

   // Only a fresh 0->1 of the frame-valid level starts work; valid_prev resets high.
   assign rise       = IN_VALID_I & ~valid_prev;
   assign IN_READY_O = (state == IDLE);

   always_ff @(posedge CLK_I or negedge RSTL_I) begin
      if (!RSTL_I) state <= IDLE;
      else         state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (rise) state_next = MUL;
         MUL:     state_next = PRND;
         PRND:    state_next = ALIGN;
         ALIGN:   state_next = ADD;
         ADD:     state_next = NORM;
         NORM:    state_next = RND;
         RND:     state_next = HOLD;
         HOLD:    if (OUT_VALID_O && OUT_READY_I) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // ---------------- MUL: operand classification and raw product ----------------
   logic        a_zero, b_zero, c_zero, a_inf, b_inf, c_inf, a_nan, b_nan, c_nan;
   logic        mul_sign, mul_spec;
   logic [31:0] mul_spec_val;
   logic [47:0] mul_man;
   logic signed [10:0] mul_exp;

   assign a_zero   = (a_q[30:23] == 8'h00);
   assign b_zero   = (b_q[30:23] == 8'h00);
   assign c_zero   = (c_q[30:23] == 8'h00);
   assign a_inf    = (a_q[30:23] == 8'hFF) && (a_q[22:0] == 23'd0);
   assign b_inf    = (b_q[30:23] == 8'hFF) && (b_q[22:0] == 23'd0);
   assign c_inf    = (c_q[30:23] == 8'hFF) && (c_q[22:0] == 23'd0);
   assign a_nan    = (a_q[30:23] == 8'hFF) && (a_q[22:0] != 23'd0);
   assign b_nan    = (b_q[30:23] == 8'hFF) && (b_q[22:0] != 23'd0);
   assign c_nan    = (c_q[30:23] == 8'hFF) && (c_q[22:0] != 23'd0);
   assign mul_sign = a_q[31] ^ b_q[31];
   assign mul_man  = {1'b1, a_q[22:0]} * {1'b1, b_q[22:0]};
   assign mul_exp  = $signed({3'b000, a_q[30:23]}) + $signed({3'b000, b_q[30:23]}) - 11'sd127;

   // A zero product passes C straight through, so a zero C keeps its own sign.
   always_comb begin
      mul_spec     = 1'b1;
      mul_spec_val = CANON_NAN;
      if (a_nan || b_nan || c_nan || (a_inf && b_zero) || (b_inf && a_zero) ||
          ((a_inf || b_inf) && c_inf && (mul_sign != c_q[31])))
         mul_spec_val = CANON_NAN;
      else if (a_inf || b_inf)
         mul_spec_val = {mul_sign, 8'hFF, 23'd0};
      else if (c_inf)
         mul_spec_val = {c_q[31], 8'hFF, 23'd0};
      else if (a_zero || b_zero)
         mul_spec_val = c_zero ? {c_q[31], 31'd0} : c_q;
      else begin
         mul_spec     = 1'b0;
         mul_spec_val = 32'd0;
      end
   end

   // ---------------- PRND: normalise and round the product to 24 bits ----------------
   logic [23:0] pr_m;
   logic        pr_g, pr_st, pr_inc;
   logic [24:0] pr_m25;
   logic signed [10:0] pr_e;
   logic [23:0] prnd_m;
   logic signed [10:0] prnd_e;

   always_comb begin
      if (pman_q[47]) begin
         pr_m  = pman_q[47:24];
         pr_g  = pman_q[23];
         pr_st = |pman_q[22:0];
         pr_e  = pexp_q + 11'sd1;
      end else begin
         pr_m  = pman_q[46:23];
         pr_g  = pman_q[22];
         pr_st = |pman_q[21:0];
         pr_e  = pexp_q;
      end
      pr_inc = pr_g & (pr_st | pr_m[0]);
      pr_m25 = {1'b0, pr_m} + {24'd0, pr_inc};
      if (pr_m25[24]) begin
         prnd_m = pr_m25[24:1];
         prnd_e = pr_e + 11'sd1;
      end else begin
         prnd_m = pr_m25[23:0];
         prnd_e = pr_e;
      end
   end

   // ---------------- ALIGN: order by magnitude, shift the smaller with G/R/S ----------------
   logic signed [10:0] c_exp, lg_e, sm_e, al_diff;
   logic [23:0] c_man, lg_m, sm_m;
   logic        lg_s, sm_s, c_bigger;
   logic [53:0] al_wide;
   logic [26:0] al_small;

   assign c_exp    = $signed({3'b000, c_q[30:23]});
   assign c_man    = c_zero ? 24'd0 : {1'b1, c_q[22:0]};
   assign c_bigger = (c_man != 24'd0) && ((c_exp > re_q) || ((c_exp == re_q) && (c_man > rm_q)));

   always_comb begin
      if (c_bigger) begin
         lg_m = c_man;  lg_e = c_exp; lg_s = c_q[31];
         sm_m = rm_q;   sm_e = re_q;  sm_s = prod_sign_q;
      end else begin
         lg_m = rm_q;   lg_e = re_q;  lg_s = prod_sign_q;
         sm_m = c_man;  sm_e = c_exp; sm_s = c_q[31];
      end
      al_diff = lg_e - sm_e;
      al_wide = 54'd0;
      if (al_diff >= 11'sd27) begin
         al_small = {26'd0, |sm_m};
      end else begin
         al_wide  = {sm_m, 3'b000, 27'd0} >> al_diff[4:0];
         al_small = {al_wide[53:28], al_wide[27] | (|al_wide[26:0])};
      end
   end

   // ---------------- ADD: signed-magnitude add/subtract ----------------
   logic [27:0] add_sum;

   assign add_sum = al_sub_q ? ({1'b0, al_lg_q} - {1'b0, al_sm_q})
                             : ({1'b0, al_lg_q} + {1'b0, al_sm_q});

   // ---------------- NORM: carry-out right shift or leading-zero left shift ----------------
   logic [4:0]  norm_lz;
   logic [26:0] norm_n;
   logic signed [10:0] norm_e;

   always_comb begin
      norm_lz = 5'd27;
      for (int i = 0; i < 27; i++)
         if (sum_q[i]) norm_lz = 5'(26 - i);
      if (sum_q[27]) begin
         norm_n = {sum_q[27:2], sum_q[1] | sum_q[0]};
         norm_e = al_exp_q + 11'sd1;
      end else begin
         norm_n = sum_q[26:0] << norm_lz;
         norm_e = al_exp_q - $signed({6'd0, norm_lz});
      end
   end

   // ---------------- RND: final rounding, range check, packing ----------------
   logic [23:0] rn_m, rnd_m;
   logic        rn_inc;
   logic [24:0] rn_m25;
   logic signed [10:0] rnd_e;
   logic [31:0] rnd_res;

   always_comb begin
      rn_m   = norm_q[26:3];
      rn_inc = norm_q[2] & (norm_q[1] | norm_q[0] | rn_m[0]);
      rn_m25 = {1'b0, rn_m} + {24'd0, rn_inc};
      if (rn_m25[24]) begin
         rnd_m = rn_m25[24:1];
         rnd_e = norm_exp_q + 11'sd1;
      end else begin
         rnd_m = rn_m25[23:0];
         rnd_e = norm_exp_q;
      end
      if (spec_q)
         rnd_res = spec_val_q;
      else if (sum_zero_q)
         rnd_res = 32'd0;
      else if (rnd_e >= 11'sd255)
         rnd_res = {al_sign_q, 8'hFF, 23'd0};
      else if (rnd_e <= 11'sd0)
         rnd_res = {al_sign_q, 31'd0};
      else
         rnd_res = {al_sign_q, rnd_e[7:0], rnd_m[22:0]};
   end

   always_ff @(posedge CLK_I or negedge RSTL_I) begin
      if (!RSTL_I) begin
         a_q         <= '0;
         b_q         <= '0;
         c_q         <= '0;
         spec_q      <= 1'b0;
         spec_val_q  <= '0;
         prod_sign_q <= 1'b0;
         pexp_q      <= '0;
         pman_q      <= '0;
         re_q        <= '0;
         rm_q        <= '0;
         al_lg_q     <= '0;
         al_sm_q     <= '0;
         al_exp_q    <= '0;
         al_sign_q   <= 1'b0;
         al_sub_q    <= 1'b0;
         sum_q       <= '0;
         sum_zero_q  <= 1'b0;
         norm_q      <= '0;
         norm_exp_q  <= '0;
         res_q       <= '0;
      end else begin
         case (state)
            IDLE: if (rise) begin
               a_q <= IN_DATA_I[31:0];
               b_q <= IN_DATA_I[63:32];
               c_q <= IN_DATA_I[95:64];
            end
            MUL: begin
               spec_q      <= mul_spec;
               spec_val_q  <= mul_spec_val;
               prod_sign_q <= mul_sign;
               pexp_q      <= mul_exp;
               pman_q      <= mul_man;
            end
            PRND: begin
               re_q <= prnd_e;
               rm_q <= prnd_m;
            end
            ALIGN: begin
               al_lg_q   <= {lg_m, 3'b000};
               al_sm_q   <= al_small;
               al_exp_q  <= lg_e;
               al_sign_q <= lg_s;
               al_sub_q  <= (lg_s != sm_s);
            end
            ADD: begin
               sum_q      <= add_sum;
               sum_zero_q <= (add_sum == 28'd0);
            end
            NORM: begin
               norm_q     <= norm_n;
               norm_exp_q <= norm_e;
            end
            RND: res_q <= rnd_res;
            default: ;
         endcase
      end
   end

   // The result register is published on the first HOLD edge, so valid rises at k+7.
   always_ff @(posedge CLK_I or negedge RSTL_I) begin
      if (!RSTL_I) begin
         valid_prev  <= 1'b1;
         OVERRUN_O   <= 1'b0;
         OUT_VALID_O <= 1'b0;
         OUT_DATA_O  <= '0;
      end else begin
         valid_prev <= IN_VALID_I;
         if (rise && (state != IDLE))
            OVERRUN_O <= 1'b1;
         if (state == HOLD) begin
            if (!OUT_VALID_O) begin
               OUT_VALID_O <= 1'b1;
               OUT_DATA_O  <= res_q;
            end else if (OUT_READY_I) begin
               OUT_VALID_O <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_fp32_mac_core.sv
// Directed bench for fp32_mac_core: hand-computed binary32 results, latency, handshake,
// overrun and reset behaviour.
module tb_fp32_mac_core;

   logic        CLK_I;
   logic        RSTL_I;
   logic        IN_VALID_I;
   logic [95:0] IN_DATA_I;
   logic        IN_READY_O;
   logic        OUT_VALID_O;
   logic        OUT_READY_I;
   logic [31:0] OUT_DATA_O;
   logic        OVERRUN_O;

   int checks = 0;
   int errors = 0;

   fp32_mac_core #(.CANON_NAN(32'h7FC00000)) dut (
      .CLK_I      (CLK_I),
      .RSTL_I     (RSTL_I),
      .IN_VALID_I (IN_VALID_I),
      .IN_DATA_I  (IN_DATA_I),
      .IN_READY_O (IN_READY_O),
      .OUT_VALID_O(OUT_VALID_O),
      .OUT_READY_I(OUT_READY_I),
      .OUT_DATA_O (OUT_DATA_O),
      .OVERRUN_O  (OVERRUN_O)
   );

   initial CLK_I = 1'b0;
   always #5 CLK_I = ~CLK_I;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   // Mimics the receive stage: valid drops at the start bit, rises once the frame is complete.
   // Returns #1 after edge k.
   task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
      @(negedge CLK_I);
      IN_VALID_I = 1'b0;
      repeat (2) @(negedge CLK_I);
      IN_DATA_I  = {c, b, a};
      IN_VALID_I = 1'b1;
      @(posedge CLK_I);
      #1;
   endtask

   task automatic waitResult(output int lat);
      lat = 0;
      while (!OUT_VALID_O && lat < 20) begin
         @(posedge CLK_I);
         #1;
         lat++;
      end
   endtask

   task automatic runOp(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] c, input logic [31:0] exp);
      int lat;
      applyStimulus(a, b, c);
      waitResult(lat);
      checkOutput({tag, " latency"}, lat, 7);
      checkOutput({tag, " data"}, OUT_DATA_O, exp);
      @(posedge CLK_I);
      #1;
      checkOutput({tag, " valid after xfer"}, OUT_VALID_O, 1'b0);
      checkOutput({tag, " in_ready after xfer"}, IN_READY_O, 1'b1);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      int lat;
      int pulses;

      RSTL_I      = 1'b0;
      IN_VALID_I  = 1'b1;
      IN_DATA_I   = '0;
      OUT_READY_I = 1'b1;
      repeat (3) @(posedge CLK_I);
      #1;
      checkOutput("reset in_ready", IN_READY_O, 1'b1);
      checkOutput("reset out_valid", OUT_VALID_O, 1'b0);
      checkOutput("reset out_data", OUT_DATA_O, 32'h0);
      checkOutput("reset overrun", OVERRUN_O, 1'b0);

      // Valid is already high when reset releases: nothing may start.
      @(negedge CLK_I);
      RSTL_I = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(posedge CLK_I);
         #1;
         checkOutput("no start on level", IN_READY_O, 1'b1);
      end
      checkOutput("no start out_valid", OUT_VALID_O, 1'b0);

      runOp("basic",        32'h3F800000, 32'h40000000, 32'h3F000000, 32'h40200000);
      checkOutput("basic overrun", OVERRUN_O, 1'b0);
      runOp("cancel",       32'h40400000, 32'hBFC00000, 32'h40900000, 32'h00000000);
      runOp("prod round",   32'h3F800001, 32'h3F800001, 32'h00000000, 32'h3F800002);
      runOp("inf times 0",  32'h7F800000, 32'h00000000, 32'h3F800000, 32'h7FC00000);
      runOp("overflow",     32'h7F7FFFFF, 32'h40000000, 32'h00000000, 32'h7F800000);
      runOp("denormal",     32'h00000001, 32'h3F800000, 32'h80000000, 32'h80000000);
      runOp("sub normal",   32'h3FC00000, 32'h3FC00000, 32'hBF800000, 32'h3FA00000);
      runOp("tie to even",  32'h3F800000, 32'h3F800000, 32'h33800000, 32'h3F800000);
      runOp("one minus ulp",32'h3F800000, 32'h3F800000, 32'hB3800000, 32'h3F7FFFFF);
      runOp("nan input",    32'h7FC12345, 32'h3F800000, 32'h3F800000, 32'h7FC00000);
      runOp("inf minus inf",32'h7F800000, 32'h40000000, 32'hFF800000, 32'h7FC00000);
      runOp("neg inf",      32'hFF800000, 32'h40000000, 32'h3F800000, 32'hFF800000);
      runOp("neg zeros",    32'h80000000, 32'h3F800000, 32'h80000000, 32'h80000000);
      runOp("pos zeros",    32'h00000000, 32'h3F800000, 32'h00000000, 32'h00000000);
      runOp("zero prod",    32'h00000000, 32'h40A00000, 32'h40490FDB, 32'h40490FDB);

      // Backpressure with an overrun frame arriving while the result is held.
      OUT_READY_I = 1'b0;
      applyStimulus(32'h3FC00000, 32'h3FC00000, 32'hBF800000);
      waitResult(lat);
      checkOutput("bp latency", lat, 7);
      for (int i = 0; i < 20; i++) begin
         @(negedge CLK_I);
         if (i == 4) IN_VALID_I = 1'b0;
         if (i == 6) begin
            IN_DATA_I  = {32'h40000000, 32'h40000000, 32'h40000000};
            IN_VALID_I = 1'b1;
         end
         @(posedge CLK_I);
         #1;
         checkOutput("bp valid held", OUT_VALID_O, 1'b1);
         checkOutput("bp data held", OUT_DATA_O, 32'h3FA00000);
      end
      checkOutput("overrun set", OVERRUN_O, 1'b1);
      @(negedge CLK_I);
      OUT_READY_I = 1'b1;
      @(posedge CLK_I);
      #1;
      checkOutput("bp xfer valid", OUT_VALID_O, 1'b0);
      checkOutput("bp xfer in_ready", IN_READY_O, 1'b1);
      pulses = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge CLK_I);
         #1;
         if (OUT_VALID_O) pulses++;
      end
      checkOutput("single transfer", pulses, 0);
      checkOutput("idle after xfer", IN_READY_O, 1'b1);
      checkOutput("data kept after xfer", OUT_DATA_O, 32'h3FA00000);

      runOp("overrun sticky op", 32'h3F800000, 32'h40000000, 32'h3F000000, 32'h40200000);
      checkOutput("overrun sticky", OVERRUN_O, 1'b1);

      // Asynchronous abort while the FSM is in ALIGN (edge k+2).
      applyStimulus(32'h3F800000, 32'h40000000, 32'h3F000000);
      repeat (2) @(posedge CLK_I);
      #1;
      RSTL_I = 1'b0;
      #1;
      checkOutput("abort in_ready", IN_READY_O, 1'b1);
      checkOutput("abort out_valid", OUT_VALID_O, 1'b0);
      checkOutput("abort out_data", OUT_DATA_O, 32'h0);
      checkOutput("abort overrun", OVERRUN_O, 1'b0);
      repeat (2) @(negedge CLK_I);
      RSTL_I = 1'b1;
      pulses = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge CLK_I);
         #1;
         if (OUT_VALID_O) pulses++;
      end
      checkOutput("no result after abort", pulses, 0);

      runOp("after abort", 32'h40400000, 32'h40000000, 32'h3F800000, 32'h40E00000);
      checkOutput("after abort overrun", OVERRUN_O, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fp32_mac_core.md
Name: fp32_mac_core

Overview:
- Consumes the 96-bit operand frame produced by the UART receive stage: three IEEE-754 binary32 words A, B and C.
- Computes R = round(round(A*B) + C) with a multi-cycle single-issue datapath.
- Presents R to the UART transmit stage over a valid/ready handshake.
- Sits between the receive stage and the transmit stage in the fp32_rx_mac_tx path.

Parameters:
- CANON_NAN, 32'h7FC00000, value driven for every NaN result.

Ports:
- CLK_I  input  1  system clock; all state updates on the rising edge.
- RSTL_I  input  1  reset; asynchronous, active-low.
- IN_VALID_I  input  1  frame-valid level from the receive stage. Reads high from reset, drops at the start bit, and rises when all 12 bytes have been received.
- IN_DATA_I  input  96  operand frame. A=[31:0], B=[63:32], C=[95:64]. Byte 0 of the serial stream is in bits [7:0].
- IN_READY_O  input-side  output  1  high only in IDLE.
- OUT_VALID_O  output  1  result valid.
- OUT_READY_I  input  1  transmit stage accepts the result.
- OUT_DATA_O  output  32  result R.
- OVERRUN_O  output  1  sticky: a frame arrived while the core was busy.

Behaviour:
- Reset:
  - all outputs are 0 except IN_READY_O=1.
  - FSM goes to IDLE.
  - The edge-detect register is set to 1, so a valid level that is already high at reset does NOT start an operation.
- Trigger: a 0->1 transition of IN_VALID_I (registered previous-sample compare). A level alone never triggers.
  - In IDLE, the rising edge latches IN_DATA_I on that clock edge (call it k) and the FSM enters MUL.
  - Outside IDLE, a rising edge sets OVERRUN_O=1 and the frame is discarded. OVERRUN_O clears only on reset.
- FSM sequence, one cycle per state: IDLE -> MUL -> PRND -> ALIGN -> ADD -> NORM -> RND -> HOLD.
  - MUL: unpack operands; 24x24 significand product; exponent sum with bias 127 removed; sign = sA^sB.
  - PRND: normalise the 48-bit product and round it to 24 bits, round-to-nearest-even.
  - ALIGN: swap so the larger-magnitude operand is first, then right-shift the smaller one.
    - Keep guard, round and sticky bits.
    - For shift >= 27, only sticky is kept.
  - ADD: add or subtract per effective sign; take the larger operand's sign.
  - NORM: leading-zero count and left shift, or a 1-bit right shift on carry-out; adjust the exponent.
  - RND: round-to-nearest-even, with mantissa carry into the exponent. Then check for overflow and underflow.
  - HOLD: OUT_VALID_O is high and OUT_DATA_O is stable.
- Latency: OUT_VALID_O rises at edge k+7.
- Handshake:
  - The transfer completes on the edge where OUT_VALID_O=1 and OUT_READY_I=1.
  - On that edge: OUT_VALID_O goes to 0, the FSM goes to IDLE and IN_READY_O goes to 1.
  - If OUT_READY_I is high on the edge k+7, the FSM still holds for one cycle; handshake completes at k+8 earliest.
  - OUT_DATA_O holds its value until the next result.
- Special values (resolved in MUL, bypassing arithmetic, same latency):
  - Exponent 0 inputs (zero and denormal) are treated as signed zero. Denormal results flush to signed zero.
  - Any NaN input, inf*0, or inf + (-inf) gives CANON_NAN.
  - inf*x (x != 0) gives signed inf, plus C if C is finite. The same rule applies for C = inf.
  - Exponent >= 255 after rounding gives signed inf, 0x7F800000 or 0xFF800000.
  - An exact zero sum of opposite-sign operands gives +0.
  - (+0) + (+0) gives +0; (-0) + (-0) gives -0.
- Reset mid-operation: the async abort returns to IDLE. The pending result is lost, no OUT_VALID_O pulse occurs, and OVERRUN_O clears.

Test Plan:
- Basic: A=0x3F800000, B=0x40000000, C=0x3F000000 with a clean 0->1 edge -> OUT_VALID_O at k+7, OUT_DATA_O=0x40200000 (2.5), OVERRUN_O=0.
- Cancellation: A=0x40400000, B=0xBFC00000, C=0x40900000 -> 0x00000000.
- Product rounding: A=B=0x3F800001, C=0 -> 0x3F800002.
- Specials:
  - A=0x7F800000, B=0, C=0x3F800000 -> 0x7FC00000.
  - A=0x7F7FFFFF, B=0x40000000, C=0 -> 0x7F800000.
  - A=0x00000001 (denormal), B=0x3F800000, C=0x80000000 -> 0x80000000.
- Backpressure and overrun:
  - Hold OUT_READY_I=0 for 20 cycles -> OUT_VALID_O and OUT_DATA_O stay stable throughout.
  - Issue a second rising edge while in HOLD -> OVERRUN_O=1 and the result is unchanged.
  - Release OUT_READY_I -> exactly one transfer, then IN_READY_O=1.
- Reset behaviour:
  - Release reset with IN_VALID_I already high -> no operation starts.
  - Assert RSTL_I during ALIGN -> all outputs return to reset values and no result is ever emitted.
  - The next frame then computes correctly.
